cdcfifo_rd_ctrl: RTL and testbench
==================================

Name: cdcfifo_rd_ctrl

Overview:
- Read-side controller for the CSI-2 RX dual-clock FIFO, running entirely in the read clock domain.
- Synchronises the Gray-coded write pointer and detects empty.
- Drives the RAM read address, absorbs the RAM's one-cycle registered-address read latency, and presents words on a valid/ready stream to the downstream packet parser.
- Returns its own Gray read pointer to the write-side controller for full detection.

Parameters:
- ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width; must match the RAM.
- SYNC_STAGES, 2, flop stages on the incoming write pointer; legal range 2..4.

Ports:
- rdclock  in  1  read-domain clock; the only clock in this block.
- reset  in  1  synchronous, active-high reset, sampled on rdclock.
- wrptr_gray  in  ADDR_WIDTH+1  Gray write pointer from the write domain; asynchronous to rdclock.
- rdptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain.
- rdaddress  out  ADDR_WIDTH  RAM read address; the RAM registers it internally.
- ram_q  in  DATA_WIDTH  RAM read data; valid one cycle after rdaddress is sampled.
- dout  out  DATA_WIDTH  output word.
- dout_valid  out  1  dout holds a word.
- dout_ready  in  1  downstream accepts; transfer occurs when valid && ready.
- empty  out  1  synchronised FIFO empty, registered.

Behaviour:
- Reset values: rd_bin=0, rdptr_gray=0, rdaddress=0, all sync flops=0, empty=1, dout=0, dout_valid=0, skid buffer empty, in-flight flag=0.
- Pointers are ADDR_WIDTH+1 bits. The MSB is the wrap bit and wraps naturally modulo 2**(ADDR_WIDTH+1).
- rdaddress = rd_bin[ADDR_WIDTH-1:0]. It is combinational from the rd_bin register, so no extra latency is added.
- wr_sync = wrptr_gray after SYNC_STAGES flops.
- empty = (rdptr_gray == wr_sync), registered. It must reflect rd_bin updates in the same cycle as the increment, so a stale empty never allows an over-read.
- Issue condition: issue = !empty_next && (occupancy + inflight) < 2, where occupancy counts the output register plus the skid entry (0..2).
- On issue:
  - rd_bin increments by 1.
  - rdptr_gray <= bin2gray(rd_bin+1).
  - inflight <= 1 for exactly one cycle.
- Latency:
  - Cycle N: rdaddress=A.
  - Edge N+1: the RAM latches A.
  - During N+1: ram_q = mem[A]; it is captured at edge N+2.
  - Result: a word is visible on dout 2 cycles after its address is issued, when the output is empty.
- Capture: if the output register is empty, or is transferring this cycle, ram_q loads it (or the skid word loads it first, keeping order). Otherwise ram_q goes to the skid entry.
- Ordering: words appear in strict write order; none are dropped or duplicated.
- Throughput: sustains 1 word/cycle with dout_ready=1 and a non-empty FIFO.
- Backpressure: dout_ready=0 holds dout/dout_valid stable. At most one additional word lands in the skid buffer, then issue stops.
- Simultaneous write and read while near empty: empty is computed from the synchronised pointer only, so a freshly written word becomes readable SYNC_STAGES+1 cycles later. This is pessimistic and safe.
- Wrap-around: reading entry 2**ADDR_WIDTH-1 continues at address 0 with the wrap bit toggled; empty is still exact.
- Reset mid-operation: in-flight RAM data and the skid contents are discarded, and all pointers return to 0. The write side must be reset in the same system reset sequence.

Optional Feature:
- Macro: CDCFIFO_RD_LEVEL_EN.
- When defined:
  - Adds output rd_level, ADDR_WIDTH+1 bits, registered.
  - rd_level = gray2bin(wr_sync) - rd_bin, modulo 2**(ADDR_WIDTH+1).
  - Reset value 0; maximum value 2**ADDR_WIDTH.
- When undefined: the port and its logic are absent and behaviour is otherwise identical.

Decomposition:
- Package cdcfifo_pkg holds:
  - functions bin2gray and gray2bin, parameterised by width;
  - constant CDCFIFO_SKID_DEPTH=2.
- Sub-module cdcfifo_sync: SYNC_STAGES-deep, WIDTH-bit flop chain with synchronous reset, instantiated for wrptr_gray.

Test Plan:
- Reset, then wrptr_gray held at 0 for 20 cycles -> empty=1, dout_valid=0, rdaddress=0, rdptr_gray=0 throughout.
- Write 3 words (0xA0,0xA1,0xA2), dout_ready=1 -> dout shows 0xA0,0xA1,0xA2 on consecutive cycles; first word appears SYNC_STAGES+3 cycles after the pointer change; rdptr_gray ends at 5'b00010 (Gray of 3); empty=1 afterwards.
- 16 words written, dout_ready toggling 1,0,0,1 -> all 16 words in order, no duplicates; dout is stable while ready=0.
- Wrap: 40 words streamed through depth 16 -> pointer wrap bit toggles at word 16 and again at word 32; data is intact; rd_bin=40 mod 32 = 8.
- Reset asserted while 2 words are buffered and 1 is in flight -> next cycle dout_valid=0, empty=1, pointers 0; no stale word appears after reset release.
- With CDCFIFO_RD_LEVEL_EN defined, write 10 words and read 4 -> rd_level=6 once synchronised; full FIFO (16 written) -> rd_level=16.

Source files
------------

// File: rtl/cdcfifo_pkg.sv
// Shared helpers for the CSI-2 RX dual-clock FIFO controllers.
package cdcfifo_pkg;

  localparam int unsigned CDCFIFO_SKID_DEPTH = 2;

  // Gray conversion is width-agnostic on zero-extended operands; callers cast back.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned width);
    logic [31:0] b;
    b = g;
    for (int unsigned k = 1; k < width; k++) begin
      b = b ^ (g >> k);
    end
    return b;
  endfunction

endpackage

// File: rtl/cdcfifo_sync.sv
// Multi-stage flop chain bringing a Gray pointer into the local clock domain.
module cdcfifo_sync #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/cdcfifo_rd_ctrl.sv
// Read-side controller of the CSI-2 RX dual-clock FIFO (rdclock domain only).
// Optional registered fill level output enabled by defining CDCFIFO_RD_LEVEL_EN.
module cdcfifo_rd_ctrl
  import cdcfifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  rdclock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   wrptr_gray,
  output logic [ADDR_WIDTH:0]   rdptr_gray,
  output logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  empty
`ifdef CDCFIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   rd_level
`endif
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH:0]   r_rd_bin;
  logic [ADDR_WIDTH:0]   r_rdptr_gray;
  logic                  r_empty;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_valid;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  r_skid_valid;

  logic [ADDR_WIDTH:0]   w_wr_sync;
  logic [ADDR_WIDTH:0]   w_rd_bin_next;
  logic [ADDR_WIDTH:0]   w_gray_next;
  logic                  w_pop;
  logic [1:0]            w_occ_next;
  logic [1:0]            w_load;
  logic                  w_issue;

  cdcfifo_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wrptr_sync (
    .i_clk (rdclock),
    .i_rst (reset),
    .i_d   (wrptr_gray),
    .o_q   (w_wr_sync)
  );

  // Occupancy is taken after this cycle's pop so back-to-back reads sustain 1 word/cycle.
  always_comb begin
    w_pop         = r_dout_valid && dout_ready;
    w_occ_next    = {1'b0, r_dout_valid} + {1'b0, r_skid_valid} - {1'b0, w_pop};
    w_load        = w_occ_next + {1'b0, r_inflight};
    w_issue       = !r_empty && (w_load < 2'(CDCFIFO_SKID_DEPTH));
    w_rd_bin_next = w_issue ? r_rd_bin + PW'(1) : r_rd_bin;
    w_gray_next   = PW'(bin2gray(32'(w_rd_bin_next)));
  end

  always_ff @(posedge rdclock) begin
    if (reset) begin
      r_rd_bin     <= '0;
      r_rdptr_gray <= '0;
      r_empty      <= 1'b1;
      r_inflight   <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else begin
      r_rd_bin     <= w_rd_bin_next;
      r_rdptr_gray <= w_gray_next;
      // Compared against the post-increment pointer so empty never lags an issue.
      r_empty      <= (w_gray_next == w_wr_sync);
      r_inflight   <= w_issue;
      if (!r_dout_valid || w_pop) begin
        if (r_skid_valid) begin
          r_dout       <= r_skid;
          r_dout_valid <= 1'b1;
          if (r_inflight) begin
            r_skid <= ram_q;
          end else begin
            r_skid_valid <= 1'b0;
          end
        end else if (r_inflight) begin
          r_dout       <= ram_q;
          r_dout_valid <= 1'b1;
        end else begin
          r_dout_valid <= 1'b0;
        end
      end else if (r_inflight) begin
        r_skid       <= ram_q;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign rdptr_gray = r_rdptr_gray;
  assign rdaddress  = r_rd_bin[ADDR_WIDTH-1:0];
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign empty      = r_empty;

`ifdef CDCFIFO_RD_LEVEL_EN
  logic [ADDR_WIDTH:0] r_rd_level;

  always_ff @(posedge rdclock) begin
    if (reset) begin
      r_rd_level <= '0;
    end else begin
      r_rd_level <= PW'(gray2bin(32'(w_wr_sync), PW)) - r_rd_bin;
    end
  end

  assign rd_level = r_rd_level;
`endif

endmodule

// File: tb/tb_cdcfifo_rd_ctrl.sv
// Scoreboard bench for cdcfifo_rd_ctrl with a behavioural registered-address RAM and write side.
module tb_cdcfifo_rd_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  wrptr_gray;
  logic [4:0]  rdptr_gray;
  logic [3:0]  rdaddress;
  logic [31:0] ram_q;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        empty;
`ifdef CDCFIFO_RD_LEVEL_EN
  logic [4:0]  rd_level;
`endif

  cdcfifo_rd_ctrl #(
    .ADDR_WIDTH  (4),
    .DATA_WIDTH  (32),
    .SYNC_STAGES (2)
  ) dut (
    .rdclock    (clk),
    .reset      (reset),
    .wrptr_gray (wrptr_gray),
    .rdptr_gray (rdptr_gray),
    .rdaddress  (rdaddress),
    .ram_q      (ram_q),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .empty      (empty)
`ifdef CDCFIFO_RD_LEVEL_EN
    ,
    .rd_level   (rd_level)
`endif
  );

  logic [31:0] mem [16];
  logic [31:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  int          rx_cnt = 0;
  int          toggles = 0;
  logic        prev_msb = 1'b0;
  logic        held = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[rdaddress];

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ {1'b0, b[4:1]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each transfer, checks held words against the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (held) check("hold_valid", 64'(dout_valid), 64'd1);
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(dout), 64'hDEAD_0000_0000);
        end else if (dout_ready) begin
          check("data", 64'(dout), 64'(exp_q.pop_front()));
          rx_cnt++;
        end else begin
          check("hold_data", 64'(dout), 64'(exp_q[0]));
        end
      end
      held = dout_valid && !dout_ready;
    end else begin
      held = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    logic [4:0] b;
    mem[wr_cnt % 16] = d;
    exp_q.push_back(d);
    wr_cnt++;
    b = 5'(wr_cnt);
    wrptr_gray = g(b);
  endtask

  task automatic track_wrap();
    if (rdptr_gray[4] != prev_msb) begin
      toggles++;
      prev_msb = rdptr_gray[4];
    end
  endtask

  task automatic stream(input int n, input logic [31:0] base, input bit bp, input int budget);
    int sent;
    int start_rx;
    int cyc;
    sent = 0;
    start_rx = rx_cnt;
    cyc = 0;
    while ((rx_cnt - start_rx) < n && cyc < budget) begin
      step();
      dout_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      cyc++;
      if (sent < n && (wr_cnt - rx_cnt) < 16) begin
        push_word(base + 32'(sent));
        sent++;
      end
      track_wrap();
    end
    check("stream_count", 64'(rx_cnt - start_rx), 64'(n));
    dout_ready = 1'b1;
  endtask

  initial begin
    int cyc;
    reset      = 1'b1;
    wrptr_gray = '0;
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) step();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_empty", 64'(empty), 64'd1);
      check("idle_valid", 64'(dout_valid), 64'd0);
      check("idle_addr", 64'(rdaddress), 64'd0);
      check("idle_rdptr", 64'(rdptr_gray), 64'd0);
    end

    // Three words, latency SYNC_STAGES+3 and back-to-back delivery
    push_word(32'hA0);
    push_word(32'hA1);
    push_word(32'hA2);
    for (int i = 0; i < 4; i++) begin
      step();
      check("lat_not_yet", 64'(dout_valid), 64'd0);
    end
    step();
    check("lat_v0", 64'(dout_valid), 64'd1);
    check("lat_d0", 64'(dout), 64'hA0);
    step();
    check("lat_v1", 64'(dout_valid), 64'd1);
    check("lat_d1", 64'(dout), 64'hA1);
    step();
    check("lat_v2", 64'(dout_valid), 64'd1);
    check("lat_d2", 64'(dout), 64'hA2);
    repeat (3) step();
    check("three_rdptr", 64'(rdptr_gray), 64'h02);
    check("three_empty", 64'(empty), 64'd1);
    check("three_valid", 64'(dout_valid), 64'd0);

    // Sixteen words under 1,0,0,1 backpressure
    stream(16, 32'h100, 1'b1, 400);
    repeat (4) step();
    check("bp_drained", 64'(exp_q.size()), 64'd0);
    check("bp_rdptr", 64'(rdptr_gray), 64'(g(5'd19)));
    check("bp_empty", 64'(empty), 64'd1);

    // Reset with words buffered and a read in flight
    dout_ready = 1'b0;
    push_word(32'h200);
    push_word(32'h201);
    push_word(32'h202);
    push_word(32'h203);
    cyc = 0;
    while (!dout_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check("mid_valid_seen", 64'(dout_valid), 64'd1);
    reset = 1'b1;
    step();
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_rdptr", 64'(rdptr_gray), 64'd0);
    check("rst_addr", 64'(rdaddress), 64'd0);
    exp_q.delete();
    wr_cnt     = 0;
    rx_cnt     = 0;
    wrptr_gray = '0;
    dout_ready = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_rst_valid", 64'(dout_valid), 64'd0);
      check("post_rst_empty", 64'(empty), 64'd1);
    end

    // Forty words through a depth-16 FIFO: two wrap-bit toggles
    prev_msb = 1'b0;
    toggles  = 0;
    stream(40, 32'h300, 1'b0, 400);
    repeat (4) begin
      step();
      track_wrap();
    end
    check("wrap_toggles", 64'(toggles), 64'd2);
    check("wrap_rdptr", 64'(rdptr_gray), 64'h0C);
    check("wrap_addr", 64'(rdaddress), 64'd8);
    check("wrap_empty", 64'(empty), 64'd1);
    check("wrap_drained", 64'(exp_q.size()), 64'd0);
`ifdef CDCFIFO_RD_LEVEL_EN
    check("wrap_level", 64'(rd_level), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
